// File: rtl/sram_128x36_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_128x36_rw_arbiter
// Brief    : Zero-initialises a 1RW SRAM macro, then shares its port between
//            two requesters (round-robin) with per-requester response FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module sram_128x36_rw_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 36,
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_write,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_write,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rs0_valid,
    input  logic              rs0_ready,
    output logic [DATA_W-1:0] rs0_data,
    output logic              rs1_valid,
    input  logic              rs1_ready,
    output logic [DATA_W-1:0] rs1_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(RESP_DEPTH - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST = '1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_INIT = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_rr_ptr;
    logic [1:0]        w_rq_valid;
    logic [1:0]        w_rq_write;
    logic [1:0]        w_rs_ready;
    logic [1:0]        w_rs_valid;
    logic [1:0]        w_has_room;
    logic [1:0]        w_elig;
    logic [1:0]        w_grant;
    logic [DATA_W-1:0] w_rs_data [2];

    assign w_rq_valid = {rq1_valid, rq0_valid};
    assign w_rq_write = {rq1_write, rq0_write};
    assign w_rs_ready = {rs1_ready, rs0_ready};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_init_cnt <= '0;
            r_rr_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_INIT) begin
                r_init_cnt <= r_init_cnt + ADDR_W'(1);
            end
            // Pointer moves to the requester that did not just win.
            if (|w_grant) begin
                r_rr_ptr <= w_grant[0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = c_ST_INIT;
            c_ST_INIT: if (r_init_cnt == c_ADDR_LAST) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  w_state_nxt = c_ST_RUN;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Reads only issue when a FIFO slot is guaranteed for the returning word.
    assign w_elig = (r_state == c_ST_RUN) ? (w_rq_valid & (w_rq_write | w_has_room)) : 2'b00;

    always_comb begin
        w_grant = w_elig;
        if (w_elig == 2'b11) begin
            w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (r_state == c_ST_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = r_init_cnt;
        end else if (w_grant[0]) begin
            sram_en    = 1'b1;
            sram_wmode = rq0_write;
            sram_addr  = rq0_addr;
            sram_wdata = rq0_wdata;
        end else if (w_grant[1]) begin
            sram_en    = 1'b1;
            sram_wmode = rq1_write;
            sram_addr  = rq1_addr;
            sram_wdata = rq1_wdata;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [DATA_W-1:0]  r_mem [RESP_DEPTH];
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_CNT_W-1:0] r_count;
        logic [DATA_W-1:0]  r_hold;
        logic               r_pend;
        logic               w_pop;
        logic [c_OCC_W-1:0] w_occ;

        assign w_rs_valid[gi] = (r_count != '0);
        assign w_pop          = w_rs_valid[gi] & w_rs_ready[gi];
        assign w_occ          = c_OCC_W'(r_count) - c_OCC_W'(w_pop) + c_OCC_W'(r_pend);
        assign w_has_room[gi] = (w_occ < c_OCC_W'(RESP_DEPTH));
        // Last delivered word is kept so the data output holds while empty.
        assign w_rs_data[gi]  = w_rs_valid[gi] ? r_mem[r_rd_ptr] : r_hold;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < RESP_DEPTH; k++) begin
                    r_mem[k] <= '0;
                end
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_hold   <= '0;
                r_pend   <= 1'b0;
            end else begin
                r_pend <= w_grant[gi] & ~w_rq_write[gi];
                if (r_pend) begin
                    r_mem[r_wr_ptr] <= sram_rdata;
                    r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_hold   <= r_mem[r_rd_ptr];
                    r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
                end
                if (r_pend && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!r_pend && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    assign init_done = (r_state == c_ST_RUN);
    assign rq0_ready = w_grant[0];
    assign rq1_ready = w_grant[1];
    assign rs0_valid = w_rs_valid[0];
    assign rs1_valid = w_rs_valid[1];
    assign rs0_data  = w_rs_data[0];
    assign rs1_data  = w_rs_data[1];

endmodule
`default_nettype wire

// File: doc/sram_128x36_rw_arbiter.md
Name: sram_128x36_rw_arbiter

Overview:
Controller and arbiter for one 128x36 single-port (1RW) SRAM macro with an enable, write-mode and 1-cycle registered-read interface.
- After reset, it zero-initialises all 128 entries.
- It then shares the single port between two requesters using round-robin arbitration.
- Read data returns to each requester through a per-requester 2-entry response FIFO with valid/ready flow control.

Parameters:
ADDR_W, 7, SRAM address width (depth = 2^ADDR_W = 128)
DATA_W, 36, SRAM word width
RESP_DEPTH, 2, entries per requester response FIFO

Ports:
clock  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
init_done  out  1  high once zero-initialisation has completed
rq0_valid / rq1_valid  in  1  request valid, requester 0 / 1
rq0_ready / rq1_ready  out  1  request accepted when valid & ready
rq0_write / rq1_write  in  1  1 = write, 0 = read
rq0_addr / rq1_addr  in  ADDR_W  request address
rq0_wdata / rq1_wdata  in  DATA_W  write data
rs0_valid / rs1_valid  out  1  read response valid
rs0_ready / rs1_ready  in  1  response consumed when valid & ready
rs0_data / rs1_data  out  DATA_W  read response data
sram_addr  out  ADDR_W  to macro address
sram_en  out  1  to macro enable
sram_wmode  out  1  to macro write mode
sram_wdata  out  DATA_W  to macro write data
sram_rdata  in  DATA_W  from macro; valid only the cycle after a read enable

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; init counter = 0; both FIFOs empty; read-pending flags cleared; round-robin pointer = requester 0.
  - Outputs: init_done = 0, rq*_ready = 0, rs*_valid = 0, rs*_data = 0, sram_en = 0, sram_wmode = 0, sram_addr = 0, sram_wdata = 0.
  - Any in-flight read is dropped.
- FSM states and transitions:
  - IDLE -> INIT unconditionally on the first clock after reset release. sram_en = 0 in IDLE.
  - INIT: sram_en = 1, sram_wmode = 1, sram_addr = counter, sram_wdata = 0. Counter increments each cycle. After writing address 127, go to RUN. INIT lasts exactly 128 cycles; rq*_ready = 0 throughout.
  - RUN: init_done = 1 and stays high until the next reset. No other transitions.
- Eligibility in RUN: requester i is eligible when rqi_valid is high and either:
  - rqi_write = 1, or
  - (fifo_count_i − pop_i) + pending_i < RESP_DEPTH, where pop_i = rsi_valid & rsi_ready in the same cycle.
- Arbitration:
  - Only one grant per cycle.
  - If both are eligible, the pointer requester wins.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer holds.
  - rqi_ready = RUN & grant_i. Ready may depend combinationally on rqi_valid and rsi_ready; a requester must not make valid depend on ready.
- SRAM drive in RUN:
  - On a grant: sram_en = 1, sram_wmode = rq_write, sram_addr/sram_wdata from the winner.
  - With no grant: sram_en = 0, sram_wmode = 0, addr = 0, wdata = 0.
- Writes: fire-and-forget; no response. A write in cycle t is visible to a read issued in cycle t+1 or later.
- Read latency:
  - Read granted in cycle t sets pending_i.
  - In cycle t+1, sram_rdata is pushed into FIFO i and pending_i clears.
  - rsi_valid is high from t+2.
  - Push and pop in the same cycle are both legal.
- FIFO: in-order, RESP_DEPTH entries. It never overflows, by construction of the eligibility rule. rsi_data reflects the head entry; it holds when empty.
- Back-to-back reads by one requester with rsi_ready held high sustain 1 read per cycle.

Test Plan:
- Reset release, no requests -> sram_en 0 for one cycle, then 128 cycles of writes to addr 0..127 with data 0, then init_done = 1; rq*_ready = 0 throughout INIT.
- After init, rq0 read addr 5 -> rs0_valid at t+2 with rs0_data = 0. Then rq0 write addr 5 = 36'h9_ABCD_1234 followed next cycle by a read of addr 5 -> rs0_data = 36'h9_ABCD_1234.
- Both requesters hold valid reads to different addresses for 6 cycles -> grants alternate 0,1,0,1,0,1; each gets in-order data.
- rs1_ready held 0 while rq1 issues reads -> exactly 2 reads accepted, then rq1_ready = 0 while rq0 keeps full throughput. Raise rs1_ready -> data drains in order and rq1 resumes.
- rq0 streams 10 reads with rs0_ready = 1 -> 10 consecutive grants, 10 responses on consecutive cycles starting t+2.
- Assert reset_n low one cycle after a read grant -> no response is ever delivered, FIFOs are empty, and INIT reruns from addr 0.
